// File: rtl/tdm_audio_rx.sv
// TDM audio receiver: deserializes a multi-slot TDM stream clocked by an
// asynchronous codec bit clock into one IO_WIDTH word per channel, and
// publishes a whole frame at once to the DSP audio input array.
module tdm_audio_rx #(
    parameter int IO_WIDTH  = 24,
    parameter int SLOT_BITS = 32,
    parameter int NUM_CH    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tdm_bclk,
    input  logic                             tdm_fsync,
    input  logic                             tdm_sdata,
    output logic [NUM_CH-1:0][IO_WIDTH-1:0]  audio_inputs,
    output logic                             frame_valid,
    output logic                             sync_err,
    input  logic                             err_clr
);

    // The frame bit counter is kept as {slot, position} so slot/position
    // need no divider for non-power-of-two geometries.
    localparam int POS_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // bclk_q[1] is the synchronized bit clock, bclk_q[2] its previous value.
    logic [2:0] bclk_q;
    logic [1:0] fsync_q;
    logic [1:0] sdata_q;

    logic bit_evt;
    logic fsync_s;
    logic sdata_s;
    logic frame_end;

    state_t                           state_q,   state_d;
    logic [POS_W-1:0]                 pos_q,     pos_d;
    logic [SLOT_W-1:0]                slot_q,    slot_d;
    logic [IO_WIDTH-1:0]              shreg_q,   shreg_d;
    logic [NUM_CH-1:0][IO_WIDTH-1:0]  staging_q, staging_d;
    logic [NUM_CH-1:0][IO_WIDTH-1:0]  audio_q,   audio_d;
    logic                             fvalid_q,  fvalid_d;
    logic                             err_q,     err_d;

    // Bring the codec signals into the clk domain; bclk gets an extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_q  <= '0;
            fsync_q <= '0;
            sdata_q <= '0;
        end else begin
            bclk_q  <= {bclk_q[1:0], tdm_bclk};
            fsync_q <= {fsync_q[0], tdm_fsync};
            sdata_q <= {sdata_q[0], tdm_sdata};
        end
    end

    assign bit_evt   = bclk_q[1] & ~bclk_q[2];
    assign fsync_s   = fsync_q[1];
    assign sdata_s   = sdata_q[1];
    assign frame_end = (slot_q == SLOT_LAST) && (pos_q == POS_LAST);

    // Framing state, bit counter and all frame data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            pos_q     <= '0;
            slot_q    <= '0;
            shreg_q   <= '0;
            staging_q <= '0;
            audio_q   <= '0;
            fvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            slot_q    <= slot_d;
            shreg_q   <= shreg_d;
            staging_q <= staging_d;
            audio_q   <= audio_d;
            fvalid_q  <= fvalid_d;
            err_q     <= err_d;
        end
    end

    // Per bit event: align on fsync, shift sample bits, stage words, publish frames.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        slot_d    = slot_q;
        shreg_d   = shreg_q;
        staging_d = staging_q;
        audio_d   = audio_q;
        fvalid_d  = 1'b0;
        // A framing error raised below overrides a simultaneous clear.
        err_d     = err_q & ~err_clr;

        if (bit_evt) begin
            case (state_q)
                HUNT: begin
                    // fsync leads slot 0 MSB by one bit.
                    if (fsync_s) begin
                        state_d = RUN;
                        pos_d   = '0;
                        slot_d  = '0;
                    end
                end
                RUN: begin
                    if (fsync_s && !frame_end) begin
                        // Early sync: drop the partial frame and realign.
                        err_d  = 1'b1;
                        pos_d  = '0;
                        slot_d = '0;
                    end else begin
                        if (int'(pos_q) < IO_WIDTH) begin
                            shreg_d = {shreg_q[IO_WIDTH-2:0], sdata_s};
                            if (int'(pos_q) == IO_WIDTH - 1) begin
                                staging_d[slot_q] = shreg_d;
                            end
                        end
                        if (frame_end) begin
                            // Publish from staging_d so a word finishing on the last bit is included.
                            audio_d  = staging_d;
                            fvalid_d = 1'b1;
                            pos_d    = '0;
                            slot_d   = '0;
                            if (!fsync_s) begin
                                err_d   = 1'b1;
                                state_d = HUNT;
                            end
                        end else if (pos_q == POS_LAST) begin
                            pos_d  = '0;
                            slot_d = slot_q + 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign audio_inputs = audio_q;
    assign frame_valid  = fvalid_q;
    assign sync_err     = err_q;

endmodule

// File: tb/tb_tdm_audio_rx.sv
// Directed bench for tdm_audio_rx: clk runs at 16x the bit clock, frames
// carry slot n = base + n in the top 24 bits and 8'hA5 padding.
module tb_tdm_audio_rx;

    localparam int NCH = 8;
    localparam int IOW = 24;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     tdm_bclk;
    logic                     tdm_fsync;
    logic                     tdm_sdata;
    logic [NCH-1:0][IOW-1:0]  audio_inputs;
    logic                     frame_valid;
    logic                     sync_err;
    logic                     err_clr;

    int total = 0;
    int bad   = 0;

    int fv_cnt     = 0;
    int dbl_cnt    = 0;
    int glitch_cnt = 0;
    logic                     prev_fv = 1'b0;
    logic [NCH-1:0][IOW-1:0]  prev_audio = '0;

    typedef struct {
        logic [23:0] base;
        logic [23:0] exp_ch0;
        logic [23:0] exp_ch7;
    } frame_vec_t;

    frame_vec_t vecs [4];

    tdm_audio_rx #(.IO_WIDTH(24), .SLOT_BITS(32), .NUM_CH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tdm_bclk     (tdm_bclk),
        .tdm_fsync    (tdm_fsync),
        .tdm_sdata    (tdm_sdata),
        .audio_inputs (audio_inputs),
        .frame_valid  (frame_valid),
        .sync_err     (sync_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Watch every cycle for frame_valid pulses, double pulses and unpublished output changes.
    always @(negedge clk) begin
        if (reset) begin
            prev_fv    = 1'b0;
            prev_audio = audio_inputs;
        end else begin
            if (frame_valid) fv_cnt++;
            if (frame_valid && prev_fv) dbl_cnt++;
            if (audio_inputs != prev_audio && !frame_valid) glitch_cnt++;
            prev_fv    = frame_valid;
            prev_audio = audio_inputs;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [23:0] base);
        for (int n = 0; n < NCH; n++) begin
            logic [23:0] w;
            w = base + 24'(n);
            chk(nm, {8'h00, audio_inputs[n]}, {8'h00, w});
        end
    endtask

    // One bit period: data changes while bclk is low, codec-style.
    task automatic send_bit(input logic fs, input logic sd);
        tdm_bclk  = 1'b0;
        tdm_fsync = fs;
        tdm_sdata = sd;
        repeat (8) @(posedge clk);
        #1;
        tdm_bclk = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Bits 0..nbits-1 of a frame; the last one carries fs_last on fsync.
    task automatic send_frame(input logic [23:0] base, input int nbits, input logic fs_last);
        for (int k = 0; k < nbits; k++) begin
            int          slot;
            int          pos;
            logic [23:0] w;
            logic [7:0]  pad;
            logic        sd;
            slot = k / 32;
            pos  = k % 32;
            w    = base + 24'(slot);
            pad  = 8'hA5;
            sd   = (pos < 24) ? w[23 - pos] : pad[31 - pos];
            send_bit((k == nbits - 1) ? fs_last : 1'b0, sd);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt0;
        logic seen;

        vecs[0] = '{base: 24'h100000, exp_ch0: 24'h100000, exp_ch7: 24'h100007};
        vecs[1] = '{base: 24'h7FFFFC, exp_ch0: 24'h7FFFFC, exp_ch7: 24'h800003};
        vecs[2] = '{base: 24'hFFFFFE, exp_ch0: 24'hFFFFFE, exp_ch7: 24'h000005};
        vecs[3] = '{base: 24'h5A5A50, exp_ch0: 24'h5A5A50, exp_ch7: 24'h5A5A57};

        reset     = 1'b1;
        tdm_bclk  = 1'b0;
        tdm_fsync = 1'b0;
        tdm_sdata = 1'b0;
        err_clr   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        chk("reset_audio", {31'd0, |audio_inputs}, 32'd0);
        chk("reset_fv", {31'd0, frame_valid}, 32'd0);
        chk("reset_err", {31'd0, sync_err}, 32'd0);

        // Back-to-back frames, each ended by the next frame's fsync.
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cnt0 = fv_cnt;
            send_frame(vecs[i].base, 256, 1'b1);
            chk("tbl_fv_count", fv_cnt, cnt0 + 1);
            chk("tbl_ch0", {8'h00, audio_inputs[0]}, {8'h00, vecs[i].exp_ch0});
            chk("tbl_ch7", {8'h00, audio_inputs[7]}, {8'h00, vecs[i].exp_ch7});
            chk_frame("tbl_frame", vecs[i].base);
            chk("tbl_err", {31'd0, sync_err}, 32'd0);
        end

        // Early fsync at bit 100: frame discarded, realigned frame published.
        cnt0 = fv_cnt;
        send_frame(24'h222220, 101, 1'b1);
        chk("early_err", {31'd0, sync_err}, 32'd1);
        chk("early_no_fv", fv_cnt, cnt0);
        chk_frame("early_hold", 24'h5A5A50);
        send_frame(24'h333330, 256, 1'b1);
        chk("realign_fv", fv_cnt, cnt0 + 1);
        chk_frame("realign_frame", 24'h333330);

        pulse_clr();
        chk("clr_err", {31'd0, sync_err}, 32'd0);

        // Early fsync while err_clr is held: the error must still show.
        cnt0 = fv_cnt;
        send_frame(24'h444440, 10, 1'b0);
        tdm_bclk  = 1'b0;
        tdm_fsync = 1'b1;
        err_clr   = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tdm_bclk = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | sync_err;
        end
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        tdm_fsync = 1'b0;
        chk("set_beats_clr", {31'd0, seen}, 32'd1);
        chk("set_beats_clr_no_fv", fv_cnt, cnt0);

        // Missing fsync at frame end: publish, flag, then hunt.
        pulse_reset();
        cnt0 = fv_cnt;
        send_bit(1'b1, 1'b0);
        send_frame(24'h555550, 256, 1'b0);
        chk("miss_fv", fv_cnt, cnt0 + 1);
        chk_frame("miss_frame", 24'h555550);
        chk("miss_err", {31'd0, sync_err}, 32'd1);
        send_frame(24'h666660, 256, 1'b0);
        chk("hunt_no_fv", fv_cnt, cnt0 + 1);
        chk_frame("hunt_hold", 24'h555550);
        chk("hunt_err_sticky", {31'd0, sync_err}, 32'd1);
        pulse_clr();
        chk("miss_clr", {31'd0, sync_err}, 32'd0);

        // Reset at bit 130 of a frame.
        send_bit(1'b1, 1'b0);
        cnt0 = fv_cnt;
        send_frame(24'h777770, 256, 1'b1);
        chk("pre_rst_fv", fv_cnt, cnt0 + 1);
        send_frame(24'h888880, 130, 1'b0);
        pulse_reset();
        chk("rst_audio", {31'd0, |audio_inputs}, 32'd0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_err", {31'd0, sync_err}, 32'd0);
        cnt0 = fv_cnt;
        send_frame(24'h999990, 200, 1'b0);
        chk("rst_no_fv", fv_cnt, cnt0);
        chk("rst_audio_hold", {31'd0, |audio_inputs}, 32'd0);
        send_bit(1'b1, 1'b0);
        send_frame(24'hABCDE0, 256, 1'b1);
        chk("post_rst_fv", fv_cnt, cnt0 + 1);
        chk_frame("post_rst_frame", 24'hABCDE0);
        chk("post_rst_err", {31'd0, sync_err}, 32'd0);

        chk("no_double_fv", dbl_cnt, 0);
        chk("no_unpublished_change", glitch_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
